// File: rtl/serial_pkg.sv
// Shared types and constants for the serial result-dump path.
// Number width matches the serial_number_encoder.
package serial_pkg;

  localparam int NUMBER_BITS  = 37;
  localparam int NUMBER_BYTES = 5;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    SEND_RE,
    WAIT_RE,
    SEND_IM,
    WAIT_IM
  } sched_state_t;

endpackage

// File: rtl/amplitude_stream_scheduler.sv
// Walks the result memory and feeds real/imag parts to the
// serial number encoder, one number per ready/available handshake.
module amplitude_stream_scheduler #(
  parameter int NUMBER_BITS = serial_pkg::NUMBER_BITS,
  parameter int ADDR_BITS   = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [ADDR_BITS-1:0]          mem_addr,
  input  logic signed [NUMBER_BITS-1:0] mem_real,
  input  logic signed [NUMBER_BITS-1:0] mem_imag,
  output logic signed [NUMBER_BITS-1:0] enc_num,
  output logic                          enc_ready,
  input  logic                          enc_available
);

  import serial_pkg::*;

  localparam logic [ADDR_BITS-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);

  sched_state_t state;
  sched_state_t state_d;

  logic signed [NUMBER_BITS-1:0] re_q;
  logic signed [NUMBER_BITS-1:0] im_q;
  logic signed [NUMBER_BITS-1:0] re_d;
  logic signed [NUMBER_BITS-1:0] im_d;
  logic signed [NUMBER_BITS-1:0] num_d;
  logic [ADDR_BITS-1:0]          addr_d;
  logic                          busy_d;
  logic                          done_d;
  logic                          ready_d;
  logic                          is_im;
  logic                          accept;

  // start is ignored in the done cycle: the dump is still closing
  assign accept = start && !done;
  assign is_im  = (state == SEND_IM) || (state == WAIT_IM);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (accept) state_d = FETCH;
      FETCH:   state_d = LATCH;
      LATCH:   state_d = SEND_RE;
      SEND_RE,
      SEND_IM: begin
        if (!enc_available)
          state_d = is_im ? WAIT_IM : WAIT_RE;
      end
      WAIT_RE: if (enc_available) state_d = SEND_IM;
      WAIT_IM: begin
        if (enc_available)
          state_d = (mem_addr == ADDR_LAST) ? IDLE : FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d  = mem_addr;
    busy_d  = busy;
    done_d  = 1'b0;
    ready_d = enc_ready;
    num_d   = enc_num;
    re_d    = re_q;
    im_d    = im_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          addr_d = '0;
          busy_d = 1'b1;
        end
      end
      FETCH: ;
      LATCH: begin
        re_d    = mem_real;
        im_d    = mem_imag;
        num_d   = re_d;
        ready_d = 1'b1;
      end
      // only a sampled low counts as acceptance
      SEND_RE,
      SEND_IM: if (!enc_available) ready_d = 1'b0;
      WAIT_RE: begin
        if (enc_available) begin
          num_d   = im_q;
          ready_d = 1'b1;
        end
      end
      WAIT_IM: begin
        if (enc_available) begin
          if (mem_addr == ADDR_LAST) begin
            done_d = 1'b1;
            busy_d = 1'b0;
            addr_d = '0;
          end else begin
            addr_d = mem_addr + ADDR_ONE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      enc_ready <= 1'b0;
      enc_num   <= '0;
      re_q      <= '0;
      im_q      <= '0;
    end else begin
      mem_addr  <= addr_d;
      busy      <= busy_d;
      done      <= done_d;
      enc_ready <= ready_d;
      enc_num   <= num_d;
      re_q      <= re_d;
      im_q      <= im_d;
    end
  end

endmodule

// File: tb/tb_amplitude_stream_scheduler.sv
// Randomized bench: memory and encoder models, expected number
// stream built from memory contents, checked every cycle.
module tb_amplitude_stream_scheduler;

  localparam int NB = 37;
  localparam int AB = 3;
  localparam int N  = 1 << AB;

  logic                 clk = 0;
  logic                 reset = 1;
  logic                 start = 0;
  logic                 busy;
  logic                 done;
  logic [AB-1:0]        mem_addr;
  logic signed [NB-1:0] mem_real = '0;
  logic signed [NB-1:0] mem_imag = '0;
  logic signed [NB-1:0] enc_num;
  logic                 enc_ready;
  logic                 enc_available = 1;

  amplitude_stream_scheduler #(.NUMBER_BITS(NB), .ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .done(done), .mem_addr(mem_addr), .mem_real(mem_real),
    .mem_imag(mem_imag), .enc_num(enc_num), .enc_ready(enc_ready),
    .enc_available(enc_available)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic signed [NB-1:0] mre [N];
  logic signed [NB-1:0] mim [N];
  logic signed [NB-1:0] expq [$];
  logic signed [NB-1:0] got [4];

  int idx = 0;
  bit active = 0;
  int ndone = 0;
  int cyc = 0;
  int rise_cyc = -100;
  int hold_mode = -1;
  int rrun = 0;
  int maxrun = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic signed [NB-1:0] rnd();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[NB-1:0];
  endfunction

  // memory: data for an address appears one cycle after it
  logic [AB-1:0] aq;
  initial forever begin
    @(negedge clk);
    aq = mem_addr;
    @(posedge clk);
    #1;
    mem_real = mre[aq];
    mem_imag = mim[aq];
  end

  // encoder: accepts after a delay, stays busy a few cycles
  initial begin
    int wcnt;
    int bcnt;
    bit r;
    bit rr;
    wcnt = -1;
    bcnt = 0;
    forever begin
      @(negedge clk);
      r = enc_ready;
      rr = reset;
      @(posedge clk);
      #1;
      if (rr) begin
        enc_available = 1;
        wcnt = -1;
        bcnt = 0;
      end else if (!enc_available) begin
        bcnt--;
        if (bcnt <= 0) enc_available = 1;
      end else if (r) begin
        if (wcnt < 0)
          wcnt = (hold_mode >= 0) ? hold_mode : $urandom_range(0, 3);
        if (wcnt == 0) begin
          enc_available = 0;
          bcnt = $urandom_range(2, 6);
          wcnt = -1;
        end else begin
          wcnt--;
        end
      end
    end
  end

  // compare process
  bit p_ready = 0;
  bit p_avail = 1;
  bit p_rst = 1;
  logic signed [NB-1:0] p_num = '0;

  always @(negedge clk) begin
    cyc++;
    if (enc_ready) rrun++;
    else rrun = 0;
    if (rrun > maxrun) maxrun = rrun;
    if (!reset && !p_rst) begin
      chk("ready_only_busy", 64'(enc_ready && !busy), 0);
      if (p_ready && p_avail)
        chk("ready_held", 64'(enc_ready), 1);
      if (!p_avail && !enc_available)
        chk("ready_in_wait", 64'(enc_ready), 0);
      if (p_ready || !p_avail)
        chk("num_stable", 64'(enc_num), 64'(p_num));
      if (p_avail && !enc_available) begin
        if (active && idx < expq.size()) begin
          chk("num_seq", 64'(enc_num), 64'(expq[idx]));
          chk("addr_seq", 64'(mem_addr), 64'(idx / 2));
          if (idx < 4) got[idx] = enc_num;
        end else begin
          chk("unexpected_accept", 64'(active), 0);
        end
        idx++;
      end
      if (!p_avail && enc_available) rise_cyc = cyc;
      if (done) begin
        chk("done_when_active", 64'(active), 1);
        chk("done_count_sent", 64'(idx), 64'(2 * N));
        chk("done_latency", 64'(cyc - rise_cyc), 1);
        chk("busy_at_done", 64'(busy), 0);
        ndone++;
        active = 0;
      end else if (active && idx > 0) begin
        chk("busy_mid", 64'(busy), 1);
      end
    end
    p_ready = enc_ready;
    p_avail = enc_available;
    p_num = enc_num;
    p_rst = reset;
  end

  task automatic begin_dump();
    expq.delete();
    for (int a = 0; a < N; a++) begin
      expq.push_back(mre[a]);
      expq.push_back(mim[a]);
    end
    idx = 0;
    active = 1;
  endtask

  // s1/s2: extra start pulses; hold_start keeps start high to done
  task automatic run_dump(input int s1, input int s2,
                          input bit hold_start);
    int d0;
    int k;
    d0 = ndone;
    @(posedge clk);
    #1;
    begin_dump();
    start = 1;
    k = 0;
    while (active && k < 4000) begin
      @(posedge clk);
      #1;
      k++;
      start = hold_start || (k == s1) || (k == s2);
    end
    start = 0;
    if (k >= 4000) begin
      chk("dump_timeout", 0, 1);
      active = 0;
    end
    @(negedge clk);
    if (hold_start) chk("start_on_done_ignored", 64'(busy), 0);
    repeat (5) @(negedge clk);
    chk("one_done", 64'(ndone - d0), 1);
    chk("idle_after", 64'(busy), 0);
    chk("addr_after", 64'(mem_addr), 0);
  endtask

  initial begin
    int k;
    for (int a = 0; a < N; a++) begin
      mre[a] = rnd();
      mim[a] = rnd();
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_addr", 64'(mem_addr), 0);
    chk("rst_ready", 64'(enc_ready), 0);
    chk("rst_num", 64'(enc_num), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_busy", 64'(busy | done | enc_ready), 0);
      chk("idle_addr", 64'(mem_addr), 0);
    end

    mre[0] = 37'sd5;
    mim[0] = -37'sd3;
    mre[1] = 37'sh1_0000_0000;
    mim[1] = -37'sd1;
    hold_mode = 0;
    run_dump(-1, -1, 0);
    chk("lit_0", 64'(got[0]), 64'(37'sd5));
    chk("lit_1", 64'(got[1]), 64'(-37'sd3));
    chk("lit_2", 64'(got[2]), 64'(37'sh1_0000_0000));
    chk("lit_3", 64'(got[3]), 64'(-37'sd1));

    hold_mode = -1;
    run_dump(-1, -1, 0);

    for (int a = 0; a < N; a++) begin
      mre[a] = rnd();
      mim[a] = rnd();
    end
    hold_mode = 20;
    maxrun = 0;
    run_dump(-1, -1, 0);
    chk("hold_run", 64'(maxrun >= 21), 1);

    hold_mode = -1;
    run_dump(3, 50, 0);
    run_dump(-1, -1, 1);

    for (int a = 0; a < N; a++) begin
      mre[a] = a;
      mim[a] = -a;
    end
    @(posedge clk);
    #1;
    begin_dump();
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    k = 0;
    while (!(idx == 6 && !enc_available) && k < 2000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("reach_wait_im2", 64'(k < 2000), 1);
    reset = 1;
    active = 0;
    @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_addr", 64'(mem_addr), 0);
    chk("midrst_ready", 64'(enc_ready), 0);
    chk("midrst_done", 64'(done), 0);
    repeat (8) @(negedge clk);
    run_dump(-1, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
